nn_neuron_mac: RTL

//  Single fixed-point neuron stage feeding the nnt top: streams N=2**ADDR_LEN signed inputs,

---
 rtl/nn_neuron_mac.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nn_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : nn_neuron_mac
// Description : Single fixed-point neuron stage. Streams 2**ADDR_LEN signed
//               inputs, multiplies each by a host-loaded weight, accumulates,
//               adds the bias, applies ReLU and emits one activation per input
//               vector on a valid/ready output.
//               Optional feature macro: NNT_SAT_EN (saturating narrowing;
//               when undefined the result wraps to DATA_LEN bits).
// Revision    : 1.0 - initial release
// ============================================================================
module nn_neuron_mac #(
    parameter int ADDR_LEN  = 2,
    parameter int DATA_LEN  = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                w_we_i,
    input  logic                w_sel_bias_i,
    input  logic [ADDR_LEN-1:0] w_addr_i,
    input  logic [DATA_LEN-1:0] w_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_LEN-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] out_data_o,
    output logic                busy_o
);

    localparam int N       = 2 ** ADDR_LEN;
    localparam int PROD_LEN = 2 * DATA_LEN;
    // Sum of N full-width products cannot exceed this width.
    localparam int ACC_LEN = PROD_LEN + ADDR_LEN;
    localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_LEN-1:0]   weight_q [N];
    logic signed [DATA_LEN-1:0]   bias_q;
    logic signed [ACC_LEN-1:0]    acc_q;
    logic        [ADDR_LEN-1:0]   idx_q;
    logic                         out_valid_q;
    logic        [DATA_LEN-1:0]   out_data_q;

    logic                         accept;
    logic signed [PROD_LEN-1:0]   prod;
    logic signed [ACC_LEN-1:0]    bias_shifted;
    logic signed [ACC_LEN-1:0]    sum_biased;
    logic signed [ACC_LEN-1:0]    shifted;
    logic        [ACC_LEN-1:0]    relu;
    logic        [DATA_LEN-1:0]   result;

    assign accept = in_valid_i && (state_q == ST_ACCUM);

    // Registered weight always read here, so a same-cycle write to weight[idx]
    // only affects later beats.
    assign prod         = $signed(in_data_i) * weight_q[idx_q];
    assign bias_shifted = {{(ACC_LEN-DATA_LEN){bias_q[DATA_LEN-1]}}, bias_q} <<< FRAC_BITS;
    assign sum_biased   = acc_q + bias_shifted;
    assign shifted      = sum_biased >>> FRAC_BITS;
    assign relu         = sum_biased[ACC_LEN-1] ? '0 : shifted;

`ifdef NNT_SAT_EN
    // ReLU output is non-negative, so any set bit at or above the sign
    // position of the narrow format means it does not fit.
    assign result = (|relu[ACC_LEN-1:DATA_LEN-1])
                  ? {1'b0, {(DATA_LEN-1){1'b1}}}
                  : relu[DATA_LEN-1:0];
`else
    assign result = relu[DATA_LEN-1:0];
    logic unused_hi_bits;
    assign unused_hi_bits = ^relu[ACC_LEN-1:DATA_LEN];
`endif

    // Host-writable weight and bias registers; writes land on the next edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) begin
                weight_q[i] <= '0;
            end
            bias_q <= '0;
        end else if (w_we_i) begin
            if (w_sel_bias_i) begin
                bias_q <= w_data_i;
            end else begin
                weight_q[w_addr_i] <= w_data_i;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  state_d = ST_ACCUM;
            ST_ACCUM: begin
                in_ready_o = 1'b1;
                if (accept && (idx_q == LAST_IDX)) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS:  state_d = ST_OUT;
            ST_OUT: begin
                if (out_valid_q && out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Accumulator, beat index and registered result.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_q + {{ADDR_LEN{prod[PROD_LEN-1]}}, prod};
                        idx_q <= idx_q + ADDR_LEN'(1);
                    end
                end
                ST_BIAS: begin
                    acc_q       <= sum_biased;
                    out_data_q  <= result;
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
`default_nettype wire
